// File: rtl/fifo_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_rr_arbiter: round-robin reader sharing one output register among FIFOs |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fifo_rr_arbiter #(
  parameter int NumPorts     = 4,
  parameter int PortIdxWidth = 2,
  parameter int DataWidth    = 85
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NumPorts-1:0]           fifo_empty,
  input  logic [NumPorts*DataWidth-1:0] fifo_data,
  output logic [NumPorts-1:0]           fifo_rd_en,
  output logic [DataWidth-1:0]          out_flit,
  output logic [PortIdxWidth-1:0]       out_port,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [PortIdxWidth-1:0] grant;
  logic [PortIdxWidth-1:0] rr_ptr;
  logic [PortIdxWidth-1:0] sel;
  logic [PortIdxWidth-1:0] grant_inc;
  logic                    sel_found;
  logic [NumPorts-1:0]     sel_onehot;

  // Scan rr_ptr, rr_ptr+1, ... wrapping at NumPorts (not 2^PortIdxWidth).
  always_comb begin : p_scan
    int                      idx;
    logic [PortIdxWidth-1:0] cand;
    sel       = '0;
    sel_found = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int i = 0; i < NumPorts; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NumPorts) idx = idx - NumPorts;
      cand = PortIdxWidth'(idx);
      if (!sel_found && !fifo_empty[cand]) begin
        sel_found = 1'b1;
        sel       = cand;
      end
    end
  end

  always_comb begin
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  end

  assign grant_inc = (grant == PortIdxWidth'(NumPorts - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en && sel_found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = HOLD;
      HOLD:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // rd_en is a flop set on entry to ISSUE, so the pulse is glitch-free and one cycle wide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= '0;
      rr_ptr     <= '0;
      fifo_rd_en <= '0;
      out_flit   <= '0;
      out_port   <= '0;
      out_valid  <= 1'b0;
    end else begin
      fifo_rd_en <= '0;
      unique case (state)
        IDLE: begin
          if (en && sel_found) begin
            grant      <= sel;
            fifo_rd_en <= sel_onehot;
          end
        end
        WAIT: begin
          out_flit  <= fifo_data[int'(grant)*DataWidth +: DataWidth];
          out_port  <= grant;
          out_valid <= 1'b1;
          rr_ptr    <= grant_inc;
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fifo_rr_arbiter: FIFO models + scoreboard bench for fifo_rr_arbiter     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fifo_rr_arbiter;

  localparam int NP = 4;
  localparam int DW = 85;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [NP-1:0]   fifo_empty;
  logic [NP*DW-1:0] fifo_data;
  logic [NP-1:0]   fifo_rd_en;
  logic [DW-1:0]   out_flit;
  logic [1:0]      out_port;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  fifo_rr_arbiter #(.NumPorts(NP), .PortIdxWidth(2), .DataWidth(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .out_flit   (out_flit),
    .out_port   (out_port),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int pulses  = 0;
  int hs      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // FIFO models: registered buf_out loaded on the edge that ends a rd_en pulse.
  logic [DW-1:0] mem [NP][16];
  int            head [NP] = '{default: 0};
  int            tail [NP] = '{default: 0};
  logic [DW-1:0] buf_out [NP] = '{default: '0};

  always @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (fifo_rd_en[p] && head[p] != tail[p]) begin
        buf_out[p] <= mem[p][head[p] % 16];
        head[p]    <= head[p] + 1;
      end
    end
  end

  always_comb begin
    fifo_empty = '0;
    fifo_data  = '0;
    for (int p = 0; p < NP; p++) begin
      fifo_empty[p]         = (head[p] == tail[p]);
      fifo_data[p*DW +: DW] = buf_out[p];
    end
  end

  logic [DW-1:0] sb_flit [$];
  logic [1:0]    sb_port [$];
  logic [NP-1:0] prev_rd = '0;

  function automatic logic [DW-1:0] mk(input int p, input int k);
    return {5'(p), 16'(k), 64'hDEAD_BEEF_0000_0000 + 64'(p * 1000 + k)};
  endfunction

  task automatic push(input int p, input logic [DW-1:0] d);
    mem[p][tail[p] % 16] = d;
    tail[p] = tail[p] + 1;
  endtask

  task automatic expect_out(input int p, input logic [DW-1:0] d);
    sb_flit.push_back(d);
    sb_port.push_back(2'(p));
  endtask

  always @(negedge clk) begin
    logic [DW-1:0] ef;
    logic [1:0]    ep;
    if (fifo_rd_en != '0) begin
      check("rd_onehot", 128'($onehot(fifo_rd_en)), 128'd1);
      check("rd_width", 128'(prev_rd), 128'd0);
      pulses++;
    end
    prev_rd = fifo_rd_en;
    if (out_valid && out_ready) begin
      hs++;
      check("sb_nonempty", 128'(sb_flit.size() > 0), 128'd1);
      if (sb_flit.size() > 0) begin
        ef = sb_flit.pop_front();
        ep = sb_port.pop_front();
        check("out_flit", 128'(out_flit), 128'(ef));
        check("out_port", 128'(out_port), 128'(ep));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd(output logic [NP-1:0] seen);
    seen = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (fifo_rd_en != '0) begin
        seen = fifo_rd_en;
        return;
      end
    end
    check("rd_timeout", 128'(fifo_rd_en != '0), 128'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy && !out_valid) return;
    end
    check("idle_timeout", 128'(busy), 128'd0);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    check("valid_timeout", 128'(out_valid), 128'd1);
  endtask

  initial begin
    logic [NP-1:0] seen;
    int            last;
    int            order [8];
    logic [DW-1:0] a5;
    rst = 1'b1; en = 1'b1; out_ready = 1'b1;
    a5 = 85'h1F_0000_0000_0000_0000_00A5;
    order = '{1, 2, 3, 0, 1, 2, 3, 0};
    tick(); tick();
    check("rst_rd_en", 128'(fifo_rd_en), 128'd0);
    check("rst_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_flit", 128'(out_flit), 128'd0);
    check("rst_port", 128'(out_port), 128'd0);
    rst = 1'b0;
    tick();

    // single port, with grant-to-valid latency
    push(2, a5); expect_out(2, a5);
    wait_rd(seen);
    check("single_rd", 128'(seen), 128'b0100);
    @(negedge clk);
    check("single_rd_off", 128'(fifo_rd_en), 128'd0);
    check("single_early", 128'(out_valid), 128'd0);
    @(negedge clk);
    check("single_valid", 128'(out_valid), 128'd1);
    check("single_port", 128'(out_port), 128'd2);
    check("single_ptr", 128'(dut.rr_ptr), 128'd3);
    wait_idle();

    // wrap-around skip
    push(1, mk(1, 0)); expect_out(1, mk(1, 0));
    wait_rd(seen);
    check("wrap_rd1", 128'(seen), 128'b0010);
    wait_idle();
    check("wrap_ptr", 128'(dut.rr_ptr), 128'd2);
    push(0, mk(0, 0)); push(3, mk(3, 0));
    expect_out(3, mk(3, 0)); expect_out(0, mk(0, 0));
    wait_rd(seen);
    check("wrap_rd3", 128'(seen), 128'b1000);
    wait_idle();
    wait_rd(seen);
    check("wrap_rd0", 128'(seen), 128'b0001);
    wait_idle();

    // fairness with all ports loaded
    for (int k = 1; k <= 2; k++)
      for (int p = 0; p < NP; p++) push(p, mk(p, k));
    for (int i = 0; i < 8; i++) expect_out(order[i], mk(order[i], 1 + i / 4));
    last = 0;
    for (int i = 0; i < 8; i++) begin
      wait_rd(seen);
      check("rr_grant", 128'(seen), 128'(4'b0001 << order[i]));
      if (i > 0) check("rr_gap", 128'(cyc - last), 128'd4);
      last = cyc;
    end
    wait_idle();

    // backpressure; port 0 arrives during HOLD
    out_ready = 1'b0;
    push(2, mk(2, 5)); expect_out(2, mk(2, 5));
    wait_valid();
    push(0, mk(0, 5)); expect_out(0, mk(0, 5));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_flit", 128'(out_flit), 128'(mk(2, 5)));
      check("bp_rd", 128'(fifo_rd_en), 128'd0);
      check("bp_busy", 128'(busy), 128'd1);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_drop", 128'(out_valid), 128'd0);
    check("bp_idle", 128'(busy), 128'd0);
    wait_rd(seen);
    check("bp_next", 128'(seen), 128'b0001);
    wait_idle();

    // enable gating
    tick();
    en = 1'b0;
    push(1, mk(1, 6)); expect_out(1, mk(1, 6));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("en_rd", 128'(fifo_rd_en), 128'd0);
      check("en_busy", 128'(busy), 128'd0);
    end
    tick();
    en = 1'b1;
    @(negedge clk);
    check("en_pre", 128'(fifo_rd_en), 128'd0);
    @(negedge clk);
    check("en_grant", 128'(fifo_rd_en), 128'b0010);
    wait_idle();

    // reset in WAIT drops the in-flight flit
    push(3, mk(3, 7)); push(3, mk(3, 8)); push(0, mk(0, 8));
    expect_out(0, mk(0, 8)); expect_out(3, mk(3, 8));
    wait_rd(seen);
    check("mr_rd", 128'(seen), 128'b1000);
    tick();
    rst = 1'b1;
    #1;
    check("mr_valid", 128'(out_valid), 128'd0);
    check("mr_rd_off", 128'(fifo_rd_en), 128'd0);
    check("mr_ptr", 128'(dut.rr_ptr), 128'd0);
    check("mr_busy", 128'(busy), 128'd0);
    tick();
    rst = 1'b0;
    wait_rd(seen);
    check("mr_restart", 128'(seen), 128'b0001);
    wait_idle();
    wait_rd(seen);
    check("mr_then3", 128'(seen), 128'b1000);
    wait_idle();

    check("sb_drained", 128'(sb_flit.size()), 128'd0);
    check("pulse_count", 128'(pulses), 128'(hs + 1));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
